// File: rtl/fifobram_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : fifobram_fifo
//  Purpose  : Single-clock FIFO on a simple dual-port BRAM. Registered pop
//             data with a one-cycle rvalid pulse, count-derived status flags,
//             and sticky overflow/underflow flags.
//  Revision : 1.0  initial release
// ============================================================================
module fifobram_fifo #(
   parameter int WIDTH             = 32,
   parameter int LOG2_DEPTH        = 5,
   parameter int ALMOSTFULL_MARGIN = 8
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  we,
   input  logic [WIDTH-1:0]      wdata,
   input  logic                  re,
   output logic [WIDTH-1:0]      rdata,
   output logic                  rvalid,
   output logic                  almostfull,
   output logic                  empty,
   output logic [LOG2_DEPTH-1:0] count,
   output logic                  overflow,
   output logic                  underflow
);

   localparam int                    DEPTH      = 2 ** LOG2_DEPTH;
   localparam logic [LOG2_DEPTH-1:0] FULL_COUNT = LOG2_DEPTH'(DEPTH - 1);
   localparam logic [LOG2_DEPTH-1:0] AF_LEVEL   = LOG2_DEPTH'(DEPTH - ALMOSTFULL_MARGIN);
   localparam logic [LOG2_DEPTH-1:0] ONE        = LOG2_DEPTH'(1);

   // Storage array: no reset so it maps onto block RAM.
   logic [WIDTH-1:0]      mem [DEPTH];
   logic [LOG2_DEPTH-1:0] wptr;
   logic [LOG2_DEPTH-1:0] rptr;
   logic                  full;
   logic                  wr_ok;
   logic                  rd_ok;

   // One slot is always kept free, so full is one short of DEPTH and the
   // pointers never meet on a live entry.
   assign full       = (count == FULL_COUNT);
   assign empty      = (count == '0);
   assign almostfull = (count >= AF_LEVEL);
   // Both acceptance decisions use the pre-operation count: a write while full
   // is dropped even if a pop frees a slot in the same cycle.
   assign wr_ok      = we & ~full;
   assign rd_ok      = re & ~empty;

   // BRAM write port.
   always_ff @(posedge clk) begin
      if (wr_ok) begin
         mem[wptr] <= wdata;
      end
   end

   // Pointers, occupancy, registered read data and sticky error flags.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wptr      <= '0;
         rptr      <= '0;
         count     <= '0;
         rdata     <= '0;
         rvalid    <= 1'b0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         rvalid <= rd_ok;
         if (wr_ok) begin
            wptr <= wptr + ONE;
         end
         if (rd_ok) begin
            rdata <= mem[rptr];
            rptr  <= rptr + ONE;
         end
         if (wr_ok && !rd_ok) begin
            count <= count + ONE;
         end else if (rd_ok && !wr_ok) begin
            count <= count - ONE;
         end
         if (we && full) begin
            overflow <= 1'b1;
         end
         if (re && empty) begin
            underflow <= 1'b1;
         end
      end
   end

endmodule
`default_nettype wire
